// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus controller: state encoding, requester
// classes, the power-on init ROM and the slow-command constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  // Requester class, used as the round-robin "last served" pointer.
  typedef enum logic {
    SRC_CMD = 1'b0,
    SRC_DAT = 1'b1
  } lcd_src_e;

  localparam int unsigned INIT_LEN = 6;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Init ROM: 8-bit bus, 2 lines, display on, clear, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = 8'h38;
      3'd1:    b = 8'h38;
      3'd2:    b = 8'h38;
      3'd3:    b = 8'h0C;
      3'd4:    b = 8'h01;
      3'd5:    b = 8'h06;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear and home need the long post-write wait; only as commands (RS=0).
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter. A loaded value N keeps done_o low for N cycles;
// the count then sticks at zero until the next load.
module lcd_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register; the owner forces a load while in reset.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780-style 8-bit LCD bus controller. Runs the power-on init sequence,
// then serialises command/data writes from two requesters with round-robin
// arbitration, generating RS/data setup, the enable strobe and the
// post-write busy wait.
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned P_PWRUP_CYC = 750000,
  parameter int unsigned P_SETUP_CYC = 2,
  parameter int unsigned P_EN_CYC    = 12,
  parameter int unsigned P_WAIT_CYC  = 2000,
  parameter int unsigned P_CLR_CYC   = 82000
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iReqCmd,
  input  logic [7:0] iCmd,
  input  logic       iReqDat,
  input  logic [7:0] iDat,
  output logic [7:0] oDato,
  output logic       oRS,
  output logic       oEnable,
  output logic       oAckCmd,
  output logic       oAckDat,
  output logic       oBusy,
  output logic       oInitDone
);

  localparam int unsigned MAX_A   = (P_PWRUP_CYC > P_SETUP_CYC) ? P_PWRUP_CYC : P_SETUP_CYC;
  localparam int unsigned MAX_B   = (P_EN_CYC > P_WAIT_CYC) ? P_EN_CYC : P_WAIT_CYC;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > P_CLR_CYC) ? MAX_C : P_CLR_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // A state lasting N cycles loads N-1: the exit edge is the one seeing zero.
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(P_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(P_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(P_EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(P_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(P_CLR_CYC - 1);

  localparam logic [2:0] LAST_INIT_IDX = 3'(INIT_LEN - 1);

  lcd_state_e       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dato_q, dato_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             ack_cmd_q, ack_cmd_d;
  logic             ack_dat_q, ack_dat_d;
  logic             init_done_q, init_done_d;
  lcd_src_e         last_q, last_d;

  logic             grant_cmd;
  logic             grant_dat;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  lcd_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i      (iClk),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state, bus latch, arbitration and init sequencing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dato_d      = dato_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    ack_cmd_d   = 1'b0;
    ack_dat_d   = 1'b0;
    grant_cmd   = 1'b0;
    grant_dat   = 1'b0;

    case (state_q)
      ST_PWRUP: begin
        if (tmr_done) begin
          state_d = ST_SETUP;
          idx_d   = '0;
          dato_d  = init_byte('0);
          rs_d    = 1'b0;
        end
      end

      ST_IDLE: begin
        if (init_done_q) begin
          grant_cmd = iReqCmd && (!iReqDat || (last_q == SRC_DAT));
          grant_dat = iReqDat && !grant_cmd;
          if (grant_cmd) begin
            state_d   = ST_SETUP;
            dato_d    = iCmd;
            rs_d      = 1'b0;
            ack_cmd_d = 1'b1;
            last_d    = SRC_CMD;
          end else if (grant_dat) begin
            state_d   = ST_SETUP;
            dato_d    = iDat;
            rs_d      = 1'b1;
            ack_dat_d = 1'b1;
            last_d    = SRC_DAT;
          end
        end
      end

      ST_SETUP: begin
        if (tmr_done) begin
          state_d = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (tmr_done) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (tmr_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == LAST_INIT_IDX) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            dato_d  = init_byte(idx_d);
            rs_d    = 1'b0;
            state_d = ST_SETUP;
          end
        end
      end

      default: begin
        state_d = ST_PWRUP;
      end
    endcase

    en_d = (state_d == ST_PULSE);
  end

  // Timer reload on every state entry; reset holds the power-up count.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_PWRUP: tmr_val = LD_PWRUP;
      ST_SETUP: tmr_val = LD_SETUP;
      ST_PULSE: tmr_val = LD_EN;
      ST_WAIT:  tmr_val = is_long_cmd(rs_d, dato_d) ? LD_CLR : LD_WAIT;
      default:  tmr_val = '0;
    endcase
    if (!iReset) begin
      tmr_load = 1'b1;
      tmr_val  = LD_PWRUP;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iReset) begin
      state_q     <= ST_PWRUP;
      idx_q       <= '0;
      dato_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      ack_cmd_q   <= 1'b0;
      ack_dat_q   <= 1'b0;
      init_done_q <= 1'b0;
      last_q      <= SRC_DAT;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dato_q      <= dato_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      ack_cmd_q   <= ack_cmd_d;
      ack_dat_q   <= ack_dat_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
    end
  end

  assign oDato     = dato_q;
  assign oRS       = rs_q;
  assign oEnable   = en_q;
  assign oAckCmd   = ack_cmd_q;
  assign oAckDat   = ack_dat_q;
  assign oInitDone = init_done_q;
  assign oBusy     = (state_q != ST_IDLE) || !init_done_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: a timeline model (each write is a start cycle plus
// a length) checked against the DUT every cycle, plus directed scenarios
// with hand-computed cycle distances and byte sequences.
module tb_lcd_bus_ctrl;

  localparam int PWR = 20;
  localparam int SU  = 2;
  localparam int EN  = 3;
  localparam int WT  = 5;
  localparam int CLR = 10;

  logic       iClk    = 1'b0;
  logic       iReset  = 1'b0;
  logic       iReqCmd = 1'b0;
  logic       iReqDat = 1'b0;
  logic [7:0] iCmd    = 8'h00;
  logic [7:0] iDat    = 8'h00;
  logic [7:0] oDato;
  logic       oRS, oEnable, oAckCmd, oAckDat, oBusy, oInitDone;

  lcd_bus_ctrl #(
    .P_PWRUP_CYC(PWR),
    .P_SETUP_CYC(SU),
    .P_EN_CYC   (EN),
    .P_WAIT_CYC (WT),
    .P_CLR_CYC  (CLR)
  ) dut (
    .iClk     (iClk),
    .iReset   (iReset),
    .iReqCmd  (iReqCmd),
    .iCmd     (iCmd),
    .iReqDat  (iReqDat),
    .iDat     (iDat),
    .oDato    (oDato),
    .oRS      (oRS),
    .oEnable  (oEnable),
    .oAckCmd  (oAckCmd),
    .oAckDat  (oAckDat),
    .oBusy    (oBusy),
    .oInitDone(oInitDone)
  );

  always #5 iClk = ~iClk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  logic [7:0] INIT_BYTES [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // ---------------- timeline model ----------------
  bit         mv = 1'b0;     // model has seen a reset edge
  int         k;             // edges since last reset edge
  bit         act, idle, idone;
  bit         last_dat;
  int         s, len, iidx;
  logic [7:0] mb;
  logic       mrs;
  logic       e_ackc, e_ackd;

  task automatic m_start(input logic [7:0] b, input logic r);
    s    = k;
    len  = SU + EN + ((!r && (b == 8'h01 || b == 8'h02)) ? CLR : WT);
    act  = 1'b1;
    idle = 1'b0;
    mb   = b;
    mrs  = r;
  endtask

  always @(posedge iClk) begin
    if (!iReset) begin
      mv = 1'b1; k = 0; act = 0; idle = 0; idone = 0; last_dat = 1;
      mb = 8'h00; mrs = 1'b0; iidx = 0; s = 0; len = 0;
      e_ackc = 1'b0; e_ackd = 1'b0;
    end else begin
      k++;
      e_ackc = 1'b0;
      e_ackd = 1'b0;
      if (!act && !idle && !idone && k == PWR) begin
        iidx = 0;
        m_start(INIT_BYTES[0], 1'b0);
      end else if (act && (k - s) == len) begin
        act = 1'b0;
        if (!idone && iidx < 5) begin
          iidx++;
          m_start(INIT_BYTES[iidx], 1'b0);
        end else begin
          idle  = 1'b1;
          idone = 1'b1;
        end
      end else if (idle) begin
        if (iReqCmd && (!iReqDat || last_dat)) begin
          m_start(iCmd, 1'b0); e_ackc = 1'b1; last_dat = 1'b0;
        end else if (iReqDat) begin
          m_start(iDat, 1'b1); e_ackd = 1'b1; last_dat = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int          md;
  logic        e_en;
  logic [13:0] ev, av;

  always @(negedge iClk) begin
    if (mv) begin
      md   = k - s;
      e_en = act && (md >= SU) && (md < SU + EN);
      ev   = {mb, mrs, e_en, e_ackc, e_ackd, !idle, idone};
      av   = {oDato, oRS, oEnable, oAckCmd, oAckDat, oBusy, oInitDone};
      check("outputs{dato,rs,en,ackc,ackd,busy,initdone}", 32'(av), 32'(ev));
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int         rise_c[$];
  logic [7:0] rise_b[$];
  logic       rise_r[$];
  int         width_q[$];
  int         n_acks = 0;
  logic       prev_en = 1'b0;

  always @(negedge iClk) begin
    if (oEnable === 1'b1 && !prev_en) begin
      rise_c.push_back(cyc); rise_b.push_back(oDato); rise_r.push_back(oRS);
    end
    if (oEnable !== 1'b1 && prev_en) width_q.push_back(cyc - rise_c[rise_c.size()-1]);
    prev_en = (oEnable === 1'b1);
    if (oAckCmd === 1'b1) n_acks++;
    if (oAckDat === 1'b1) n_acks++;
  end

  // ---------------- helpers ----------------
  task automatic do_write(input bit is_cmd, input logic [7:0] b, output int ack_cyc);
    ack_cyc = -1;
    if (is_cmd) begin iCmd = b; iReqCmd = 1'b1; end
    else        begin iDat = b; iReqDat = 1'b1; end
    for (int n = 0; n < 100; n++) begin
      @(negedge iClk);
      if ((is_cmd ? oAckCmd : oAckDat) === 1'b1) begin ack_cyc = cyc; break; end
    end
    iReqCmd = 1'b0;
    iReqDat = 1'b0;
    check("ack_seen", 32'(ack_cyc >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge iClk);
      if (oBusy === 1'b0) begin at = cyc; break; end
    end
    check("idle_reached", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_init(input int limit);
    int at;
    at = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge iClk);
      if (oInitDone === 1'b1) begin at = cyc; break; end
    end
    check("init_done_reached", 32'(at >= 0), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int  a, idl, base, nacc;
    byte seq[$];

    repeat (3) @(negedge iClk);
    check("rst_dato", 32'(oDato), 32'h00);
    check("rst_rs", 32'(oRS), 32'd0);
    check("rst_en", 32'(oEnable), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd1);
    check("rst_initdone", 32'(oInitDone), 32'd0);

    // init sequence
    iReset = 1'b1;
    wait_init(400);
    @(negedge iClk);
    check("init_pulses", 32'(rise_b.size()), 32'd6);
    if (rise_b.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check("init_byte", 32'(rise_b[i]), 32'(INIT_BYTES[i]));
        check("init_rs", 32'(rise_r[i]), 32'd0);
        check("init_width", 32'(width_q[i]), 32'd3);
      end
      for (int i = 0; i < 4; i++) check("init_spacing", 32'(rise_c[i+1] - rise_c[i]), 32'd10);
      check("spacing_after_clear", 32'(rise_c[5] - rise_c[4]), 32'd15);
    end
    check("post_init_busy", 32'(oBusy), 32'd0);

    // single data write
    base = rise_b.size();
    do_write(1'b0, 8'h41, a);
    wait_idle(50, idl);
    check("dat_idle_after_ack", 32'(idl - a), 32'd10);
    check("dat_byte", 32'(rise_b[base]), 32'h41);
    check("dat_rs", 32'(rise_r[base]), 32'd1);
    check("dat_en_delay", 32'(rise_c[base] - a), 32'd2);
    check("dat_width", 32'(width_q[base]), 32'd3);

    // contended requests, both held through three grants
    iCmd = 8'h80; iDat = 8'h42; iReqCmd = 1'b1; iReqDat = 1'b1;
    for (int n = 0; n < 200 && seq.size() < 3; n++) begin
      @(negedge iClk);
      if (oAckCmd === 1'b1) seq.push_back("C");
      if (oAckDat === 1'b1) seq.push_back("D");
    end
    iReqCmd = 1'b0; iReqDat = 1'b0;
    check("rr_grants", 32'(seq.size()), 32'd3);
    if (seq.size() >= 3) begin
      check("rr_first_cmd", 32'(seq[0]), 32'("C"));
      check("rr_then_dat", 32'(seq[1]), 32'("D"));
      check("rr_cmd_again", 32'(seq[2]), 32'("C"));
    end
    wait_idle(100, idl);

    // long vs ordinary command wait
    do_write(1'b1, 8'h01, a);
    wait_idle(50, idl);
    check("clear_cmd_len", 32'(idl - a), 32'd15);
    do_write(1'b1, 8'h80, a);
    wait_idle(50, idl);
    check("plain_cmd_len", 32'(idl - a), 32'd10);

    // reset in the second cycle of a data pulse
    do_write(1'b0, 8'h55, a);
    for (int n = 0; n < 20 && oEnable !== 1'b1; n++) @(negedge iClk);
    check("pulse_started", 32'(oEnable), 32'd1);
    nacc = n_acks;
    @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);
    check("rst_mid_en", 32'(oEnable), 32'd0);
    check("rst_mid_dato", 32'(oDato), 32'h00);
    check("rst_mid_initdone", 32'(oInitDone), 32'd0);
    base = rise_b.size();
    @(negedge iClk);
    iReset = 1'b1;
    wait_init(400);
    @(negedge iClk);
    check("replay_pulses", 32'(rise_b.size() - base), 32'd6);
    if (rise_b.size() - base >= 6)
      for (int i = 0; i < 6; i++) check("replay_byte", 32'(rise_b[base+i]), 32'(INIT_BYTES[i]));
    check("no_extra_ack", 32'(n_acks), 32'(nacc));
    check("total_acks", 32'(n_acks), 32'd7);

    repeat (3) @(negedge iClk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_bus_ctrl.md
LCD_BUS_CTRL -- requirements
Module: lcd_bus_ctrl

Interface
REQ-001 Parameter P_PWRUP_CYC, default 750000: power-up wait before the first init write (15 ms at 50 MHz).
REQ-002 Parameter P_SETUP_CYC, default 2: RS/data setup cycles before the oEnable rising edge.
REQ-003 Parameter P_EN_CYC, default 12: oEnable high width in cycles.
REQ-004 Parameter P_WAIT_CYC, default 2000: post-write wait for ordinary bytes (40 us).
REQ-005 Parameter P_CLR_CYC, default 82000: post-write wait for command 0x01 or 0x02 with RS=0 (1.64 ms).
REQ-006 Ports: iClk in 1, sole clock; all logic on the rising edge.
REQ-007 Ports: iReset in 1, synchronous, active-low reset.
REQ-008 Ports: iReqCmd in 1, command write request; iCmd in 8, command byte.
REQ-009 Ports: iReqDat in 1, data write request; iDat in 8, data byte.
REQ-010 Ports: oDato out 8, LCD data bus; oRS out 1, register select; oEnable out 1, LCD strobe.
REQ-011 Ports: oAckCmd and oAckDat out 1, one-cycle accept pulses; oBusy out 1; oInitDone out 1.

Function
REQ-012 The block is the single owner of oDato/oRS/oEnable; all LCD writes are serialised through it.
REQ-013 FSM states: PWRUP, IDLE, SETUP, PULSE, WAIT.
REQ-014 PWRUP: hold for P_PWRUP_CYC cycles, then load init byte 0 into SETUP.
REQ-015 Init sequence, RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06; each byte goes through SETUP->PULSE->WAIT; requests are not acknowledged during init.
REQ-016 After the WAIT of init byte 5, go to IDLE and set oInitDone=1; oInitDone stays 1 until reset.
REQ-017 IDLE with oInitDone=1 and a request sampled at edge N: at edge N, latch byte and RS (cmd: RS=0, data: RS=1) into oDato/oRS, enter SETUP, and pulse the matching ack high for cycle N..N+1 only.
REQ-018 SETUP: oEnable=0 for P_SETUP_CYC cycles; PULSE: oEnable=1 for exactly P_EN_CYC cycles; WAIT: oEnable=0 for P_WAIT_CYC, or P_CLR_CYC when RS=0 and the byte is 0x01 or 0x02; then IDLE.
REQ-019 oDato/oRS are stable from SETUP entry until the next accept; they never change while oEnable=1.
REQ-020 Arbitration is round-robin: if both requests are high in IDLE, grant the class not served last; a single requester is granted immediately.
REQ-021 The last-served pointer resets to "data", so the first contended grant goes to cmd.
REQ-022 IDLE lasts at least one cycle between writes; a request held continuously is re-granted at most once per write.
REQ-023 A requester must hold iReq and its byte until its ack; a dropped request before ack is not served; an iReq still high in the cycle after ack is a new request.
REQ-024 oBusy = (state != IDLE) or oInitDone=0.
REQ-025 Delay counter width is ceil(log2(max parameter+1)); the counter reloads on every state entry; no wrap-around is reachable.

Reset
REQ-026 While iReset=0 at a clock edge: state=PWRUP, init index=0, oDato=0x00, oRS=0, oEnable=0, oAckCmd=0, oAckDat=0, oInitDone=0, oBusy=1, pointer="data".
REQ-027 A reset during any state, including PULSE, drops oEnable in the cycle after the edge and restarts the full init sequence; the in-flight request is lost and is not acked again.

Structure
REQ-028 Shared package lcd_pkg holds the state encoding, the init ROM (6 x 8-bit), and constants CMD_CLEAR=0x01 and CMD_HOME=0x02.
REQ-029 One sub-module, lcd_timer: loadable down-counter with load value and done flag; lcd_bus_ctrl instantiates it once.

Verification
REQ-030 Bench parameters: P_PWRUP_CYC=20, P_SETUP_CYC=2, P_EN_CYC=3, P_WAIT_CYC=5, P_CLR_CYC=10.
REQ-031 Release reset, no requests -> 6 oEnable pulses of 3 cycles each with bytes 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and RS=0; wait after 0x01 is 10 cycles; then oInitDone=1, oBusy=0.
REQ-032 After init, iReqDat=1 with iDat=0x41 -> oAckDat for one cycle, oRS=1, oDato=0x41, oEnable high 3 cycles starting 2 cycles after ack, back to IDLE 5 cycles later.
REQ-033 iReqCmd=1 (0x80) and iReqDat=1 (0x42) both held -> cmd served first, then data, then cmd again; acks never overlap.
REQ-034 iReqCmd=1 with iCmd=0x01 -> post-pulse wait of 10 cycles; with iCmd=0x80 -> 5 cycles.
REQ-035 Assert iReset=0 during the second cycle of a data PULSE -> oEnable=0 next cycle, all outputs at reset values, full init replays, and no extra ack is issued.
